pc_unit: RTL and testbench

Parametrised program-counter unit for the multicycle MIPS core, replacing the single-register PC. It holds the PC and computes the next PC internally for sequential, branch, jump, call, return, exception and exception-return flows. It also keeps an exception PC (EPC) and a small return-address stack (RAS). It sits between the control FSM, which drives the mode and enable, and the memory address mux.

---
 rtl/pc_unit.sv | 147 ++++++++++++++
 tb/tb_pc_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// =============================================================================
// pc_unit - PC register with next-PC select, exception PC and circular RAS. Rev 1.0
// =============================================================================
module pc_unit #(
   parameter int                     WORD_LENGTH  = 32,
   parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [WORD_LENGTH-1:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int                     RAS_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [2:0]                   pc_mode,
   input  logic                         exc_req,
   input  logic [WORD_LENGTH-1:0]       data_in,
   input  logic [15:0]                  offset,
   input  logic [25:0]                  target,
   output logic [WORD_LENGTH-1:0]       pc_out,
   output logic [WORD_LENGTH-1:0]       pc_plus4,
   output logic [WORD_LENGTH-1:0]       epc_out,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_empty,
   output logic                         ras_full,
   output logic                         ras_overflow,
   output logic                         ras_underflow,
   output logic                         misaligned
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(RAS_DEPTH);
   localparam logic [WORD_LENGTH-1:0] WORD_BYTES = WORD_LENGTH'(4);

   localparam logic [2:0] MODE_LOAD   = 3'd0;
   localparam logic [2:0] MODE_INC    = 3'd1;
   localparam logic [2:0] MODE_BRANCH = 3'd2;
   localparam logic [2:0] MODE_JUMP   = 3'd3;
   localparam logic [2:0] MODE_CALL   = 3'd4;
   localparam logic [2:0] MODE_RETURN = 3'd5;
   localparam logic [2:0] MODE_HOLD   = 3'd6;
   localparam logic [2:0] MODE_ERET   = 3'd7;

   logic [WORD_LENGTH-1:0] pc_q, pc_d;
   logic [WORD_LENGTH-1:0] epc_q, epc_d;
   logic [WORD_LENGTH-1:0] ras_q [RAS_DEPTH];
   logic [WORD_LENGTH-1:0] ras_d [RAS_DEPTH];
   logic [PTR_W-1:0]       top_q, top_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic [WORD_LENGTH-1:0] pc_inc;
   logic [WORD_LENGTH-1:0] br_off;
   logic [WORD_LENGTH-1:0] branch_tgt;
   logic [WORD_LENGTH-1:0] jump_tgt;
   logic [PTR_W-1:0]       push_ptr;
   logic                   empty_w;
   logic                   full_w;

   assign pc_inc     = pc_q + WORD_BYTES;
   assign br_off     = {{(WORD_LENGTH-18){offset[15]}}, offset, 2'b00};
   assign branch_tgt = pc_inc + br_off;
   assign jump_tgt   = {pc_inc[WORD_LENGTH-1:28], target, 2'b00};
   assign push_ptr   = top_q + PTR_W'(1);
   assign empty_w    = (count_q == '0);
   assign full_w     = (count_q == FULL_COUNT);

   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      ras_d   = ras_q;
      top_d   = top_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (exc_req) begin
         epc_d = pc_q;
         pc_d  = EXC_VECTOR;
      end else if (enable) begin
         case (pc_mode)
            MODE_LOAD:   pc_d = data_in;
            MODE_INC:    pc_d = pc_inc;
            MODE_BRANCH: pc_d = branch_tgt;
            MODE_JUMP:   pc_d = jump_tgt;
            MODE_CALL: begin
               // Writing one past the top overwrites the oldest entry when full.
               pc_d            = jump_tgt;
               top_d           = push_ptr;
               ras_d[push_ptr] = pc_inc;
               if (full_w) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            MODE_RETURN: begin
               if (!empty_w) begin
                  pc_d    = ras_q[top_q];
                  top_d   = top_q - PTR_W'(1);
                  count_d = count_q - CNT_W'(1);
               end else begin
                  pc_d  = data_in;
                  unf_d = 1'b1;
               end
            end
            MODE_HOLD:   pc_d = pc_q;
            MODE_ERET:   pc_d = epc_q;
            default:     pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ras_q   <= ras_d;
      end
   end

   assign pc_out        = pc_q;
   assign pc_plus4      = pc_inc;
   assign epc_out       = epc_q;
   assign ras_count     = count_q;
   assign ras_empty     = empty_w;
   assign ras_full      = full_w;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
   assign misaligned    = (pc_q[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// tb_pc_unit: directed and random stimulus against a queue-based PC/RAS model;
// expected responses are queued and compared by an independent monitor.
module tb_pc_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RST_V = 32'h0040_0000;
   localparam logic [31:0] EXC_V = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [2:0]  pc_mode = 3'd6;
   logic        exc_req = 1'b0;
   logic [31:0] data_in = '0;
   logic [15:0] offset = '0;
   logic [25:0] target = '0;
   logic [31:0] pc_out, pc_plus4, epc_out;
   logic [2:0]  ras_count;
   logic        ras_empty, ras_full, ras_overflow, ras_underflow, misaligned;

   pc_unit #(
      .WORD_LENGTH (32),
      .RESET_VECTOR(RST_V),
      .EXC_VECTOR  (EXC_V),
      .RAS_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .pc_mode      (pc_mode),
      .exc_req      (exc_req),
      .data_in      (data_in),
      .offset       (offset),
      .target       (target),
      .pc_out       (pc_out),
      .pc_plus4     (pc_plus4),
      .epc_out      (epc_out),
      .ras_count    (ras_count),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full),
      .ras_overflow (ras_overflow),
      .ras_underflow(ras_underflow),
      .misaligned   (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      int          count;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] m_pc  = RST_V;
   logic [31:0] m_epc = '0;
   logic [31:0] m_ras[$];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the RAS is an unbounded-in-spirit list that forgets its
   // oldest element once it would exceed DEPTH.
   task automatic step(input logic en, input logic [2:0] mode, input logic exc,
                       input logic [31:0] din, input logic [15:0] off, input logic [25:0] tgt);
      exp_t               e;
      logic [31:0]        p4;
      logic signed [31:0] soff;
      @(negedge clk);
      enable  = en;
      pc_mode = mode;
      exc_req = exc;
      data_in = din;
      offset  = off;
      target  = tgt;
      p4      = m_pc + 32'd4;
      soff    = $signed(off);
      e.ovf   = 1'b0;
      e.unf   = 1'b0;
      if (exc) begin
         m_epc = m_pc;
         m_pc  = EXC_V;
      end else if (en) begin
         case (mode)
            3'd0: m_pc = din;
            3'd1: m_pc = p4;
            3'd2: m_pc = p4 + 32'(soff * 4);
            3'd3: m_pc = {p4[31:28], tgt, 2'b00};
            3'd4: begin
               m_ras.push_back(p4);
               if (m_ras.size() > DEPTH) begin
                  m_ras.delete(0);
                  e.ovf = 1'b1;
               end
               m_pc = {p4[31:28], tgt, 2'b00};
            end
            3'd5: begin
               if (m_ras.size() > 0) m_pc = m_ras.pop_back();
               else begin
                  m_pc  = din;
                  e.unf = 1'b1;
               end
            end
            3'd6: m_pc = m_pc;
            default: m_pc = m_epc;
         endcase
      end
      e.pc    = m_pc;
      e.epc   = m_epc;
      e.count = m_ras.size();
      exp_q.push_back(e);
   endtask

   // Reset asserted between edges while a CALL is being presented.
   task automatic do_reset();
      @(negedge clk);
      enable  = 1'b1;
      pc_mode = 3'd4;
      exc_req = 1'b0;
      target  = 26'($urandom);
      #2 reset = 1'b0;
      #1;
      chk("rst_pc", pc_out, RST_V);
      chk("rst_epc", epc_out, 32'h0);
      chk("rst_count", 32'(ras_count), 32'h0);
      chk("rst_empty", 32'(ras_empty), 32'h1);
      chk("rst_full", 32'(ras_full), 32'h0);
      chk("rst_ovf", 32'(ras_overflow), 32'h0);
      chk("rst_unf", 32'(ras_underflow), 32'h0);
      m_pc  = RST_V;
      m_epc = '0;
      m_ras.delete();
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("pc_out", pc_out, mon_e.pc);
         chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
         chk("epc_out", epc_out, mon_e.epc);
         chk("ras_count", 32'(ras_count), 32'(mon_e.count));
         chk("ras_empty", 32'(ras_empty), 32'(mon_e.count == 0));
         chk("ras_full", 32'(ras_full), 32'(mon_e.count == DEPTH));
         chk("ras_overflow", 32'(ras_overflow), 32'(mon_e.ovf));
         chk("ras_underflow", 32'(ras_underflow), 32'(mon_e.unf));
         chk("misaligned", 32'(misaligned), 32'(mon_e.pc[1:0] != 2'b00));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time %0t reached limit 500000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      do_reset();
      repeat (3) step(1'b1, 3'd1, 1'b0, 32'h0, 16'h0, 26'h0);
      repeat (2) step(1'b0, 3'd4, 1'b0, 32'h1, 16'h0, 26'h3);
      step(1'b1, 3'd0, 1'b0, 32'h0040_0010, 16'h0, 26'h0);
      step(1'b1, 3'd2, 1'b0, 32'h0, 16'hFFFF, 26'h0);
      step(1'b1, 3'd2, 1'b0, 32'h0, 16'h0003, 26'h0);
      step(1'b1, 3'd0, 1'b0, 32'hFFFF_FFFC, 16'h0, 26'h0);
      step(1'b1, 3'd1, 1'b0, 32'h0, 16'h0, 26'h0);
      step(1'b1, 3'd0, 1'b0, 32'h0040_0000, 16'h0, 26'h0);
      step(1'b1, 3'd4, 1'b0, 32'h0, 16'h0, 26'h010_0040);
      step(1'b1, 3'd5, 1'b0, 32'h0, 16'h0, 26'h0);
      step(1'b1, 3'd5, 1'b0, 32'h0040_1234, 16'h0, 26'h0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 3'd0, 1'b0, 32'h0041_0000 + 32'(i) * 32'h100, 16'h0, 26'h0);
         step(1'b1, 3'd4, 1'b0, 32'h0, 16'h0, 26'h012_3400 + 26'(i));
      end
      repeat (5) step(1'b1, 3'd5, 1'b0, 32'h0050_0000, 16'h0, 26'h0);
      step(1'b1, 3'd0, 1'b0, 32'h0040_0040, 16'h0, 26'h0);
      step(1'b0, 3'd4, 1'b1, 32'h0, 16'h0, 26'h3);
      step(1'b1, 3'd7, 1'b0, 32'h0, 16'h0, 26'h0);
      step(1'b1, 3'd0, 1'b0, 32'h0040_0000, 16'h0, 26'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 1'b0, 32'h0, 16'h0, 26'h010_0000 + 26'(i));
      do_reset();
      step(1'b1, 3'd5, 1'b0, 32'h0040_2000, 16'h0, 26'h0);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(99));
         if (r == 0) begin
            do_reset();
         end else begin
            step(r < 85, 3'($urandom), r > 94,
                 (r % 2 == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                 16'($urandom), 26'($urandom));
         end
      end

      @(posedge clk);
      #3;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
